// File: rtl/vga_scroll_animator_pkg.sv
// Shared definitions for the vga_scroll_animator block: mode encodings,
// direction flag values and the per-channel bus slice helper.
package vga_anim_pkg;

    typedef enum logic [1:0] {
        MODE_BOUNCE  = 2'b00,
        MODE_CRUISE  = 2'b01,
        MODE_FREEZE  = 2'b10,
        MODE_RESTART = 2'b11
    } mode_e;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    // Least-significant bit of channel ch inside a bus packed width bits per channel.
    function automatic int ch_lsb(input int ch, input int width);
        return ch * width;
    endfunction

endpackage

// File: rtl/vga_scroll_animator_if.sv
// Control/status bundle of the scroll animator: vsync and mode controls in,
// packed per-channel offsets/velocities and frame status out.
interface vga_scroll_animator_if #(
    parameter int NUM_CH = 2,
    parameter int POS_W  = 10,
    parameter int VEL_W  = 8
);
    logic                      vsync;
    logic [1:0]                mode;
    logic                      pause;
    logic [NUM_CH*POS_W-1:0]   offset;
    logic [NUM_CH*VEL_W-1:0]   velocity;
    logic                      frame_tick;
    logic [15:0]               frame_cnt;

    modport master (
        output vsync, mode, pause,
        input  offset, velocity, frame_tick, frame_cnt
    );

    modport slave (
        input  vsync, mode, pause,
        output offset, velocity, frame_tick, frame_cnt
    );
endinterface

// File: rtl/vga_scroll_animator_scroll_channel.sv
// One scroll channel: offset, signed velocity and bounce direction, updated
// once per frame tick according to the global animation mode.
module scroll_channel
    import vga_anim_pkg::*;
#(
    parameter int POS_W = 10,
    parameter int VEL_W = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    tick_i,
    input  mode_e                   mode_i,
    input  logic signed [VEL_W-1:0] step_i,
    input  logic signed [VEL_W-1:0] vel_max_i,
    input  logic signed [VEL_W-1:0] vel_min_i,
    output logic [POS_W-1:0]        offset_o,
    output logic signed [VEL_W-1:0] velocity_o
);

    logic [POS_W-1:0]        offset_q, offset_d;
    logic signed [VEL_W-1:0] vel_q, vel_d;
    logic                    dir_q, dir_d;

    // One guard bit so the step cannot wrap before it is compared to the bounds.
    logic signed [VEL_W:0]   vel_ext_s, step_ext_s, max_ext_s, min_ext_s, vn_up_s, vn_dn_s;
    logic [POS_W-1:0]        offset_adv_s;

    // Widened velocity arithmetic and the sign-extended offset advance.
    always_comb begin
        vel_ext_s    = {vel_q[VEL_W-1], vel_q};
        step_ext_s   = {step_i[VEL_W-1], step_i};
        max_ext_s    = {vel_max_i[VEL_W-1], vel_max_i};
        min_ext_s    = {vel_min_i[VEL_W-1], vel_min_i};
        vn_up_s      = vel_ext_s + step_ext_s;
        vn_dn_s      = vel_ext_s - step_ext_s;
        offset_adv_s = offset_q + POS_W'(vel_q);
    end

    // Next-state selection for the channel on a frame tick.
    always_comb begin
        offset_d = offset_q;
        vel_d    = vel_q;
        dir_d    = dir_q;
        if (tick_i) begin
            case (mode_i)
                MODE_BOUNCE: begin
                    offset_d = offset_adv_s;
                    if (dir_q == DIR_UP) begin
                        if (vn_up_s >= max_ext_s) begin
                            vel_d = vel_max_i;
                            dir_d = DIR_DOWN;
                        end else begin
                            vel_d = vn_up_s[VEL_W-1:0];
                        end
                    end else begin
                        if (vn_dn_s <= min_ext_s) begin
                            vel_d = vel_min_i;
                            dir_d = DIR_UP;
                        end else begin
                            vel_d = vn_dn_s[VEL_W-1:0];
                        end
                    end
                end
                MODE_CRUISE: begin
                    offset_d = offset_adv_s;
                end
                MODE_FREEZE: begin
                    offset_d = offset_q;
                end
                MODE_RESTART: begin
                    offset_d = {POS_W{1'b0}};
                    vel_d    = {VEL_W{1'b0}};
                    dir_d    = DIR_UP;
                end
                default: begin
                    offset_d = offset_q;
                end
            endcase
        end else begin
            offset_d = offset_q;
        end
    end

    // Channel state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            offset_q <= {POS_W{1'b0}};
            vel_q    <= {VEL_W{1'b0}};
            dir_q    <= DIR_UP;
        end else begin
            offset_q <= offset_d;
            vel_q    <= vel_d;
            dir_q    <= dir_d;
        end
    end

    assign offset_o   = offset_q;
    assign velocity_o = vel_q;

endmodule

// File: rtl/vga_scroll_animator.sv
// Frame-synchronous scroll animator: detects the vsync active edge in the pixel
// clock domain and steps NUM_CH scroll channels once per frame.
module vga_scroll_animator
    import vga_anim_pkg::*;
#(
    parameter int POS_W     = 10,
    parameter int VEL_W     = 8,
    parameter int NUM_CH    = 2,
    parameter int VEL_MAX   = 20,
    parameter int VEL_MIN   = -10,
    parameter int STEP      = 1,
    parameter bit VSYNC_POL = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    vga_scroll_animator_if.slave  anim_io
);

    logic        vs_act_s, tick_int_s;
    logic        vs_q, vs_d;
    logic        arm_q, arm_d;
    logic        tick_q, tick_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    mode_e       mode_s;

    logic [POS_W-1:0] off_s [NUM_CH];
    logic [VEL_W-1:0] vel_s [NUM_CH];

    // arm_q stays low until vsync has been seen inactive, so a vsync that is
    // already active when reset releases cannot produce a tick.
    always_comb begin
        vs_act_s    = (anim_io.vsync == VSYNC_POL);
        tick_int_s  = vs_act_s & ~vs_q & arm_q & ~anim_io.pause;
        mode_s      = mode_e'(anim_io.mode);
        vs_d        = vs_act_s;
        arm_d       = arm_q | ~vs_act_s;
        tick_d      = tick_int_s;
        if (tick_int_s) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
        end else begin
            frame_cnt_d = frame_cnt_q;
        end
    end

    // Edge detector history, frame pulse and frame counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_q        <= 1'b0;
            arm_q       <= 1'b0;
            tick_q      <= 1'b0;
            frame_cnt_q <= 16'd0;
        end else begin
            vs_q        <= vs_d;
            arm_q       <= arm_d;
            tick_q      <= tick_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        scroll_channel #(
            .POS_W (POS_W),
            .VEL_W (VEL_W)
        ) u_ch (
            .clk        (clk),
            .rst_n      (rst_n),
            .tick_i     (tick_int_s),
            .mode_i     (mode_s),
            .step_i     (VEL_W'(STEP * (k + 1))),
            .vel_max_i  (VEL_W'(VEL_MAX)),
            .vel_min_i  (VEL_W'(VEL_MIN)),
            .offset_o   (off_s[k]),
            .velocity_o (vel_s[k])
        );
    end

    // Pack channel state onto the output buses.
    always_comb begin
        anim_io.offset   = {(NUM_CH*POS_W){1'b0}};
        anim_io.velocity = {(NUM_CH*VEL_W){1'b0}};
        for (int k = 0; k < NUM_CH; k++) begin
            anim_io.offset[ch_lsb(k, POS_W) +: POS_W]   = off_s[k];
            anim_io.velocity[ch_lsb(k, VEL_W) +: VEL_W] = vel_s[k];
        end
    end

    assign anim_io.frame_tick = tick_q;
    assign anim_io.frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_vga_scroll_animator.sv
// Directed bench: default-parameter DUT plus a VEL_MAX=19 twin sharing the same stimulus.
module tb_vga_scroll_animator;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    vga_scroll_animator_if #(.NUM_CH(2), .POS_W(10), .VEL_W(8)) bus0 ();
    vga_scroll_animator_if #(.NUM_CH(2), .POS_W(10), .VEL_W(8)) bus1 ();

    assign bus1.vsync = bus0.vsync;
    assign bus1.mode  = bus0.mode;
    assign bus1.pause = bus0.pause;

    vga_scroll_animator dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .anim_io (bus0.slave)
    );

    vga_scroll_animator #(.VEL_MAX(19)) dut19 (
        .clk     (clk),
        .rst_n   (rst_n),
        .anim_io (bus1.slave)
    );

    // One frame: vsync inactive for two cycles, then active; tick lands one edge later.
    task automatic frame();
        @(negedge clk);
        bus0.vsync = 1'b1;
        repeat (2) @(negedge clk);
        bus0.vsync = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        bus0.vsync = 1'b0;
        bus0.mode  = 2'b00;
        bus0.pause = 1'b0;
        rst_n      = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (bus0.frame_tick !== 1'b0) begin n_bad++; $display("FAIL reset_tick got %b exp 0", bus0.frame_tick); end
        n_cmp++; if (bus0.frame_cnt !== 16'd0) begin n_bad++; $display("FAIL reset_cnt got %0d exp 0", bus0.frame_cnt); end
        n_cmp++; if (bus0.offset !== 20'd0) begin n_bad++; $display("FAIL reset_offset got %h exp 0", bus0.offset); end
        n_cmp++; if (bus0.velocity !== 16'd0) begin n_bad++; $display("FAIL reset_velocity got %h exp 0", bus0.velocity); end
    endtask

    task automatic test_first_tick();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_cmp++; if (bus0.frame_tick !== 1'b0) begin n_bad++; $display("FAIL first_no_tick cyc %0d got %b exp 0", i, bus0.frame_tick); end
        end
        n_cmp++; if (bus0.frame_cnt !== 16'd0) begin n_bad++; $display("FAIL first_cnt_held got %0d exp 0", bus0.frame_cnt); end
        bus0.vsync = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++; if (bus0.frame_tick !== 1'b0) begin n_bad++; $display("FAIL first_pre_edge got %b exp 0", bus0.frame_tick); end
        bus0.vsync = 1'b0;
        @(negedge clk);
        n_cmp++; if (bus0.frame_tick !== 1'b1) begin n_bad++; $display("FAIL first_tick_high got %b exp 1", bus0.frame_tick); end
        n_cmp++; if (bus0.frame_cnt !== 16'd1) begin n_bad++; $display("FAIL first_cnt got %0d exp 1", bus0.frame_cnt); end
        @(negedge clk);
        n_cmp++; if (bus0.frame_tick !== 1'b0) begin n_bad++; $display("FAIL first_tick_width got %b exp 0", bus0.frame_tick); end
        n_cmp++; if ($signed(bus0.velocity[7:0]) !== 1) begin n_bad++; $display("FAIL first_ch0_vel got %0d exp 1", $signed(bus0.velocity[7:0])); end
        n_cmp++; if ($signed(bus0.velocity[15:8]) !== 2) begin n_bad++; $display("FAIL first_ch1_vel got %0d exp 2", $signed(bus0.velocity[15:8])); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_bounce();
        for (int t = 2; t <= 50; t++) begin
            frame();
            if (t == 3) begin
                n_cmp++; if (bus0.offset[9:0] !== 10'd3) begin n_bad++; $display("FAIL bounce_t3_ch0_off got %0d exp 3", bus0.offset[9:0]); end
                n_cmp++; if ($signed(bus0.velocity[7:0]) !== 3) begin n_bad++; $display("FAIL bounce_t3_ch0_vel got %0d exp 3", $signed(bus0.velocity[7:0])); end
                n_cmp++; if (bus0.offset[19:10] !== 10'd6) begin n_bad++; $display("FAIL bounce_t3_ch1_off got %0d exp 6", bus0.offset[19:10]); end
            end
            if (t == 10) begin
                n_cmp++; if ($signed(bus0.velocity[15:8]) !== 20) begin n_bad++; $display("FAIL bounce_t10_ch1_vel got %0d exp 20", $signed(bus0.velocity[15:8])); end
                n_cmp++; if ($signed(bus1.velocity[15:8]) !== 19) begin n_bad++; $display("FAIL bounce_t10_max19_ch1_vel got %0d exp 19", $signed(bus1.velocity[15:8])); end
            end
            if (t == 11) begin
                n_cmp++; if ($signed(bus0.velocity[15:8]) !== 18) begin n_bad++; $display("FAIL bounce_t11_ch1_vel got %0d exp 18", $signed(bus0.velocity[15:8])); end
                n_cmp++; if ($signed(bus1.velocity[15:8]) !== 17) begin n_bad++; $display("FAIL bounce_t11_max19_ch1_vel got %0d exp 17", $signed(bus1.velocity[15:8])); end
            end
            if (t == 20) begin
                n_cmp++; if ($signed(bus0.velocity[7:0]) !== 20) begin n_bad++; $display("FAIL bounce_t20_ch0_vel got %0d exp 20", $signed(bus0.velocity[7:0])); end
                n_cmp++; if (bus0.offset[9:0] !== 10'd190) begin n_bad++; $display("FAIL bounce_t20_ch0_off got %0d exp 190", bus0.offset[9:0]); end
                n_cmp++; if ($signed(bus1.velocity[7:0]) !== 18) begin n_bad++; $display("FAIL bounce_t20_max19_ch0_vel got %0d exp 18", $signed(bus1.velocity[7:0])); end
            end
            if (t == 21) begin
                n_cmp++; if ($signed(bus0.velocity[7:0]) !== 19) begin n_bad++; $display("FAIL bounce_t21_ch0_vel got %0d exp 19", $signed(bus0.velocity[7:0])); end
                n_cmp++; if (bus0.offset[9:0] !== 10'd210) begin n_bad++; $display("FAIL bounce_t21_ch0_off got %0d exp 210", bus0.offset[9:0]); end
            end
            if (t == 50) begin
                n_cmp++; if ($signed(bus0.velocity[7:0]) !== -10) begin n_bad++; $display("FAIL bounce_t50_ch0_vel got %0d exp -10", $signed(bus0.velocity[7:0])); end
                n_cmp++; if (bus0.offset[9:0] !== 10'd355) begin n_bad++; $display("FAIL bounce_t50_ch0_off got %0d exp 355", bus0.offset[9:0]); end
                n_cmp++; if ($signed(bus0.velocity[15:8]) !== 0) begin n_bad++; $display("FAIL bounce_t50_ch1_vel got %0d exp 0", $signed(bus0.velocity[15:8])); end
                n_cmp++; if (bus0.offset[19:10] !== 10'd350) begin n_bad++; $display("FAIL bounce_t50_ch1_off got %0d exp 350", bus0.offset[19:10]); end
                n_cmp++; if ($signed(bus1.velocity[7:0]) !== -8) begin n_bad++; $display("FAIL bounce_t50_max19_ch0_vel got %0d exp -8", $signed(bus1.velocity[7:0])); end
                n_cmp++; if (bus0.frame_cnt !== 16'd50) begin n_bad++; $display("FAIL bounce_t50_cnt got %0d exp 50", bus0.frame_cnt); end
            end
        end
    endtask

    task automatic test_wrap();
        bus0.mode = 2'b01;
        for (int c = 1; c <= 36; c++) begin
            frame();
            if (c == 35) begin
                n_cmp++; if (bus0.offset[9:0] !== 10'd5) begin n_bad++; $display("FAIL wrap_pre_off got %0d exp 5", bus0.offset[9:0]); end
                n_cmp++; if ($signed(bus0.velocity[7:0]) !== -10) begin n_bad++; $display("FAIL wrap_pre_vel got %0d exp -10", $signed(bus0.velocity[7:0])); end
            end
            if (c == 36) begin
                n_cmp++; if (bus0.offset[9:0] !== 10'd1019) begin n_bad++; $display("FAIL wrap_off got %0d exp 1019", bus0.offset[9:0]); end
                n_cmp++; if (bus0.offset[19:10] !== 10'd350) begin n_bad++; $display("FAIL wrap_ch1_off got %0d exp 350", bus0.offset[19:10]); end
                n_cmp++; if (bus0.frame_cnt !== 16'd86) begin n_bad++; $display("FAIL wrap_cnt got %0d exp 86", bus0.frame_cnt); end
            end
        end
    endtask

    task automatic test_freeze();
        bus0.mode = 2'b10;
        repeat (5) frame();
        n_cmp++; if (bus0.offset[9:0] !== 10'd1019) begin n_bad++; $display("FAIL freeze_ch0_off got %0d exp 1019", bus0.offset[9:0]); end
        n_cmp++; if ($signed(bus0.velocity[7:0]) !== -10) begin n_bad++; $display("FAIL freeze_ch0_vel got %0d exp -10", $signed(bus0.velocity[7:0])); end
        n_cmp++; if (bus0.offset[19:10] !== 10'd350) begin n_bad++; $display("FAIL freeze_ch1_off got %0d exp 350", bus0.offset[19:10]); end
        n_cmp++; if (bus0.frame_cnt !== 16'd91) begin n_bad++; $display("FAIL freeze_cnt got %0d exp 91", bus0.frame_cnt); end
    endtask

    task automatic test_pause();
        bus0.pause = 1'b1;
        bus0.mode  = 2'b01;
        repeat (3) frame();
        n_cmp++; if (bus0.frame_cnt !== 16'd91) begin n_bad++; $display("FAIL pause_cnt got %0d exp 91", bus0.frame_cnt); end
        n_cmp++; if (bus0.offset[9:0] !== 10'd1019) begin n_bad++; $display("FAIL pause_ch0_off got %0d exp 1019", bus0.offset[9:0]); end
        bus0.pause = 1'b0;
    endtask

    task automatic test_restart();
        bus0.mode = 2'b11;
        frame();
        n_cmp++; if (bus0.offset !== 20'd0) begin n_bad++; $display("FAIL restart_off got %h exp 0", bus0.offset); end
        n_cmp++; if (bus0.velocity !== 16'd0) begin n_bad++; $display("FAIL restart_vel got %h exp 0", bus0.velocity); end
        n_cmp++; if (bus0.frame_cnt !== 16'd92) begin n_bad++; $display("FAIL restart_cnt got %0d exp 92", bus0.frame_cnt); end
        bus0.mode = 2'b00;
        frame();
        n_cmp++; if ($signed(bus0.velocity[7:0]) !== 1) begin n_bad++; $display("FAIL restart_up_ch0 got %0d exp 1", $signed(bus0.velocity[7:0])); end
        n_cmp++; if ($signed(bus0.velocity[15:8]) !== 2) begin n_bad++; $display("FAIL restart_up_ch1 got %0d exp 2", $signed(bus0.velocity[15:8])); end
        n_cmp++; if (bus0.offset !== 20'd0) begin n_bad++; $display("FAIL restart_up_off got %h exp 0", bus0.offset); end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        bus0.vsync = 1'b1;
        repeat (2) @(negedge clk);
        bus0.vsync = 1'b0;
        @(posedge clk);
        #2;
        n_cmp++; if (bus0.frame_tick !== 1'b1) begin n_bad++; $display("FAIL arst_pre_tick got %b exp 1", bus0.frame_tick); end
        n_cmp++; if ($signed(bus0.velocity[7:0]) !== 2) begin n_bad++; $display("FAIL arst_pre_vel got %0d exp 2", $signed(bus0.velocity[7:0])); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (bus0.frame_tick !== 1'b0) begin n_bad++; $display("FAIL arst_tick got %b exp 0", bus0.frame_tick); end
        n_cmp++; if (bus0.frame_cnt !== 16'd0) begin n_bad++; $display("FAIL arst_cnt got %0d exp 0", bus0.frame_cnt); end
        n_cmp++; if (bus0.offset !== 20'd0) begin n_bad++; $display("FAIL arst_off got %h exp 0", bus0.offset); end
        n_cmp++; if (bus0.velocity !== 16'd0) begin n_bad++; $display("FAIL arst_vel got %h exp 0", bus0.velocity); end
        n_cmp++; if (bus1.velocity !== 16'd0) begin n_bad++; $display("FAIL arst_max19_vel got %h exp 0", bus1.velocity); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_first_tick();
        test_bounce();
        test_wrap();
        test_freeze();
        test_pause();
        test_restart();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
